// File: rtl/cnn_pkg.sv
// Fixed-point types and arithmetic helpers shared by the streaming convolution core.
package cnn_pkg;

  localparam int PIX_W  = 16;
  localparam int WGT_W  = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef logic signed [WGT_W-1:0] weight_t;

  // Bits needed to hold values 0..v-1 (0 for v<=1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Counter width for a 0..v-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v <= 2) ? 1 : clog2(v);
  endfunction

  // Accumulator wide enough that the full N*K*K product sum cannot overflow.
  function automatic int acc_width(input int dw, input int ww, input int n, input int k);
    return dw + ww + clog2(n * k * k);
  endfunction

  // Round-half-up shift by frac, then saturate to a signed dw-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int dw, input int frac);
    logic signed [63:0] r, hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r  = (frac > 0) ? ((acc + (64'sd1 <<< (frac - 1))) >>> frac) : acc;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Per-channel cascade of row delay lines addressed by the column counter.
// taps[0] is the pixel one row above the current beat, taps[ROWS-1] the oldest.
module conv_line_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int ROWS  = 2,
  parameter int AW    = 2
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [AW-1:0]            addr,
  input  logic [DW-1:0]            din,
  output logic [ROWS-1:0][DW-1:0]  taps
);

  logic [DW-1:0] mem [ROWS][DEPTH];

  // Read the column under the current address from every stored row.
  always_comb begin
    taps = '0;
    for (int t = 0; t < ROWS; t++) taps[t] = mem[t][addr];
  end

  // Push the new pixel into row 0 and age each stored row by one line.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][addr] <= din;
      for (int t = 1; t < ROWS; t++) mem[t][addr] <= mem[t-1][addr];
    end
  end

endmodule

// File: rtl/conv_stream_core.sv
// Streaming valid-only KxK convolution with stride, one output channel,
// three-register MAC pipeline (products, sum, round/saturate/relu).
module conv_stream_core
  import cnn_pkg::*;
#(
  parameter int N_p    = 1,
  parameter int K_p    = 3,
  parameter int R_p    = 4,
  parameter int C_p    = 4,
  parameter int S_p    = 1,
  parameter int DW_p   = 16,
  parameter int WW_p   = 16,
  parameter int FRAC_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [N_p*DW_p-1:0]              in_data_i,
  input  logic [N_p*K_p*K_p*WW_p-1:0]      weights_i,
  input  logic                             relu_en_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DW_p-1:0]                  out_data_o,
  output logic                             out_last_o
);

  localparam int NT       = N_p * K_p * K_p;
  localparam int PW       = DW_p + WW_p;
  localparam int AW       = acc_width(DW_p, WW_p, N_p, K_p);
  localparam int RW       = cnt_w(R_p);
  localparam int CW       = cnt_w(C_p);
  localparam int ROW_LAST = R_p - 1 - ((R_p - K_p) % S_p);
  localparam int COL_LAST = C_p - 1 - ((C_p - K_p) % S_p);

  logic                 en, accept, win_ok, is_last;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [2:0]           vld_pipe, last_pipe;

  logic [N_p-1:0][K_p-1:0][DW_p-1:0]          col_vec;
  logic [N_p-1:0][K_p-1:0][K_p-1:0][DW_p-1:0] win, win_nx;
  logic [NT-1:0][PW-1:0]                      prod_d, prod_q;
  logic signed [AW-1:0]                       sum_d, acc_q;
  logic [DW_p-1:0]                            res, out_q;

  // Whole pipeline freezes while a result waits on a stalled consumer.
  assign en          = !(vld_pipe[2] && !out_ready_i);
  assign in_ready_o  = en;
  assign accept      = in_valid_i & en;
  assign out_valid_o = vld_pipe[2];
  assign out_last_o  = last_pipe[2];
  assign out_data_o  = out_q;

  // Raster position of the beat being offered; advances only on acceptance.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == CW'(C_p - 1)) begin
        col <= '0;
        row <= (row == RW'(R_p - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window completeness and end-of-frame detection for the current beat.
  always_comb begin
    int r, c;
    r       = int'(row);
    c       = int'(col);
    win_ok  = (r >= K_p - 1) && (c >= K_p - 1) &&
              ((r - K_p + 1) % S_p == 0) && ((c - K_p + 1) % S_p == 0);
    is_last = win_ok && (r == ROW_LAST) && (c == COL_LAST);
  end

  // Per-channel line buffers feed the new window column; bottom row is the live pixel.
  for (genvar ch = 0; ch < N_p; ch++) begin : g_ch
    assign col_vec[ch][K_p-1] = in_data_i[ch*DW_p +: DW_p];
    if (K_p > 1) begin : g_lb
      logic [K_p-2:0][DW_p-1:0] taps;
      conv_line_buffer #(.DW(DW_p), .DEPTH(C_p), .ROWS(K_p-1), .AW(CW)) u_lb (
        .clk  (clk_i),
        .en   (accept),
        .addr (col),
        .din  (in_data_i[ch*DW_p +: DW_p]),
        .taps (taps)
      );
      for (genvar t = 0; t < K_p - 1; t++) begin : g_tap
        assign col_vec[ch][K_p-2-t] = taps[t];
      end
    end
  end

  // Next window: shift left by one column, append the incoming column on the right.
  always_comb begin
    win_nx = win;
    for (int ch = 0; ch < N_p; ch++)
      for (int i = 0; i < K_p; i++) begin
        for (int j = 0; j < K_p - 1; j++) win_nx[ch][i][j] = win[ch][i][j+1];
        win_nx[ch][i][K_p-1] = col_vec[ch][i];
      end
  end

  // Window register moves one column per accepted beat.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) win <= '0;
    else if (accept) win <= win_nx;
  end

  // Full-width signed products of the window that the accepted beat completes.
  always_comb begin
    int idx;
    logic signed [PW-1:0] a, b;
    prod_d = '0;
    for (int ch = 0; ch < N_p; ch++)
      for (int i = 0; i < K_p; i++)
        for (int j = 0; j < K_p; j++) begin
          idx         = (ch * K_p + i) * K_p + j;
          a           = PW'($signed(win_nx[ch][i][j]));
          b           = PW'($signed(weights_i[idx*WW_p +: WW_p]));
          prod_d[idx] = a * b;
        end
  end

  // Sum of all products, sign-extended into the accumulator width.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NT; k++) sum_d = sum_d + AW'($signed(prod_q[k]));
  end

  // Round, saturate and optionally clamp negatives.
  always_comb begin
    res = DW_p'(sat_round(64'(acc_q), DW_p, FRAC_p));
    if (relu_en_i && res[DW_p-1]) res = '0;
  end

  // MAC data stages; data registers carry no reset, only the valid bits do.
  always_ff @(posedge clk_i) begin
    if (en) begin
      prod_q <= prod_d;
      acc_q  <= sum_d;
    end
  end

  // Valid / last shift registers and the output data register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      out_q     <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[1:0], accept & win_ok};
      last_pipe <= {last_pipe[1:0], accept & is_last};
      if (vld_pipe[1]) out_q <= res;
    end
  end

endmodule

// File: tb/tb_conv_stream_core.sv
// Directed bench: 4x4/S1 core plus a 6x6/S2 core, hand-computed results.
module tb_conv_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [15:0]   px;
  logic [143:0]  wts;
  logic          relu;
  logic          v4, v6, rdy4, rdy6, or4, or6, ov4, ov6, ol4, ol6;
  logic [15:0]   od4, od6;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] q4d[$], q6d[$];
  logic        q4l[$], q6l[$];
  int          q4c[$], q6c[$];

  conv_stream_core #(.N_p(1), .K_p(3), .R_p(4), .C_p(4), .S_p(1),
                     .DW_p(16), .WW_p(16), .FRAC_p(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .in_valid_i(v4), .in_ready_o(rdy4),
    .in_data_i(px), .weights_i(wts), .relu_en_i(relu), .out_valid_o(ov4),
    .out_ready_i(or4), .out_data_o(od4), .out_last_o(ol4));

  conv_stream_core #(.N_p(1), .K_p(3), .R_p(6), .C_p(6), .S_p(2),
                     .DW_p(16), .WW_p(16), .FRAC_p(8)) dut6 (
    .clk_i(clk), .reset_n_i(rst_n), .in_valid_i(v6), .in_ready_o(rdy6),
    .in_data_i(px), .weights_i(wts), .relu_en_i(relu), .out_valid_o(ov6),
    .out_ready_i(or6), .out_data_o(od6), .out_last_o(ol6));

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every handshaken result, with the cycle stamp it was seen.
  always @(negedge clk) begin
    if (ov4 && or4) begin q4d.push_back(od4); q4l.push_back(ol4); q4c.push_back(cyc); end
    if (ov6 && or6) begin q6d.push_back(od6); q6l.push_back(ol6); q6c.push_back(cyc); end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int sel, input logic [15:0] d, output int acc_cyc);
    int n;
    logic got;
    n = 0; got = 1'b0; acc_cyc = 0;
    px = d;
    if (sel == 6) v6 = 1'b1; else v4 = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = (sel == 6) ? rdy6 : rdy4;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    v4 = 1'b0; v6 = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame(input int sel, input bit ramp, input logic [15:0] val,
                       input int mark, output int mark_cyc);
    int dim, a;
    dim = (sel == 6) ? 6 : 4;
    mark_cyc = 0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) begin
        send(sel, ramp ? 16'((dim * r + c) * 256) : val, a);
        if (r * dim + c == mark) mark_cyc = a;
      end
  endtask

  // Pop four results and compare data plus last flag (last only on the 4th).
  task automatic check4(input string tag, input int sel,
                        input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ev [4];
    logic [15:0] d;
    logic        l;
    ev = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      if ((sel == 6) ? (q6d.size() == 0) : (q4d.size() == 0)) begin
        chk($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
      end else begin
        if (sel == 6) begin d = q6d.pop_front(); l = q6l.pop_front(); void'(q6c.pop_front()); end
        else          begin d = q4d.pop_front(); l = q4l.pop_front(); void'(q4c.pop_front()); end
        chk($sformatf("%s_d%0d", tag, i), 32'(d), 32'(ev[i]));
        chk($sformatf("%s_l%0d", tag, i), 32'(l), (i == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    int m, m2;
    logic [15:0] hold;
    rst_n = 1'b0; v4 = 1'b0; v6 = 1'b0; or4 = 1'b1; or6 = 1'b1;
    px = '0; relu = 1'b0; wts = {9{16'h0100}};

    // Reset state
    #12;
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_last",  32'(ol4), 32'd0);
    chk("rst_data",  32'(od4), 32'd0);
    chk("rst_ready", 32'(rdy4), 32'd1);
    chk("rst_valid6", 32'(ov6), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant frame then ramp frame back-to-back; latency from beat (2,2)
    frame(4, 1'b0, 16'h0100, 10, m);
    frame(4, 1'b1, 16'h0000, -1, m2);
    idle(8);
    if (q4c.size() > 0) chk("latency", 32'(q4c[0]), 32'(m + 3));
    else                chk("latency_none", 32'd0, 32'd1);
    check4("ones", 4, 16'h0900, 16'h0900, 16'h0900, 16'h0900);
    check4("ramp", 4, 16'h2D00, 16'h3600, 16'h5100, 16'h5A00);
    chk("ramp_extra", 32'(q4d.size()), 32'd0);

    // Positive saturation
    wts = {9{16'h7F00}};
    frame(4, 1'b0, 16'h7F00, -1, m);
    idle(8);
    check4("satp", 4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);

    // Negative result, relu off then on
    wts = {9{16'hFF00}};
    frame(4, 1'b0, 16'h0100, -1, m);
    idle(8);
    check4("neg", 4, 16'hF700, 16'hF700, 16'hF700, 16'hF700);
    relu = 1'b1;
    frame(4, 1'b0, 16'h0100, -1, m);
    idle(8);
    check4("relu", 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    relu = 1'b0;
    wts = {9{16'h0100}};

    // Stride 2 on 6x6: four outputs, last at (4,4) i.e. beat 28
    frame(6, 1'b0, 16'h0100, 28, m);
    idle(8);
    if (q6c.size() == 4) chk("s2_last_pos", 32'(q6c[3]), 32'(m + 3));
    else                 chk("s2_count", 32'(q6c.size()), 32'd4);
    check4("s2", 6, 16'h0900, 16'h0900, 16'h0900, 16'h0900);
    chk("s2_extra", 32'(q6d.size()), 32'd0);

    // Five-cycle output stall during a streaming ramp frame
    fork
      begin
        int n;
        n = 0;
        while (!ov4 && n < 100) begin @(posedge clk); #1; n++; end
        hold = od4;
        or4 = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", 32'(rdy4), 32'd0);
          chk("stall_valid", 32'(ov4), 32'd1);
          chk("stall_hold",  32'(od4), 32'(hold));
          @(posedge clk); #1;
        end
        or4 = 1'b1;
      end
    join_none
    frame(4, 1'b1, 16'h0000, -1, m);
    idle(12);
    check4("stall", 4, 16'h2D00, 16'h3600, 16'h5100, 16'h5A00);
    chk("stall_extra", 32'(q4d.size()), 32'd0);

    // Mid-frame asynchronous reset after 7 beats, then a clean frame
    for (int i = 0; i < 7; i++) send(4, 16'(i * 256), m);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov4), 32'd0);
    chk("mid_rst_last",  32'(ol4), 32'd0);
    chk("mid_rst_data",  32'(od4), 32'd0);
    chk("mid_rst_ready", 32'(rdy4), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    frame(4, 1'b1, 16'h0000, -1, m);
    idle(8);
    check4("post_rst", 4, 16'h2D00, 16'h3600, 16'h5100, 16'h5A00);
    chk("post_rst_extra", 32'(q4d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
